// File: rtl/memshare_shift_seq_buffer.sv
// Sequence-tagged FIFO between the RFMU shift-pattern output and the L1PA shifter.
// Optional same-cycle bypass when empty: define MEMSHARE_SEQBUF_BYPASS_EN.
module memshare_shift_seq_buffer #(
  parameter int SHARE_GROUP_SIZE = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int MAX_SEQ_LEN      = 4,
  localparam int SHIFT_W = (SHARE_GROUP_SIZE > 1) ? $clog2(SHARE_GROUP_SIZE) : 1,
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               isGtr_i,
  input  logic               shift_vld_i,
  output logic               stall_o,
  output logic [SHIFT_W-1:0] l1pa_shift_o,
  output logic               l1pa_last_o,
  output logic               l1pa_vld_o,
  input  logic               l1pa_rdy_i,
  output logic [CNT_W-1:0]   seq_cnt_o,
  output logic               ovf_o,
  output logic               seqlen_err_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SLW = (MAX_SEQ_LEN > 1) ? $clog2(MAX_SEQ_LEN) : 1;
  localparam logic [AW:0]     DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     MAXLEN   = (AW+1)'(MAX_SEQ_LEN);
  localparam logic [SLW-1:0]  LEN_LAST = SLW'(MAX_SEQ_LEN - 1);

  logic [SHIFT_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        occ;
  logic [SLW-1:0]     seq_len;
  logic [CNT_W-1:0]   seq_cnt;
  logic               ovf, seqlen_err;

  logic               empty, full, pop, bypass, accept, push;
  logic               force_last, last_new, head_last, cnt_inc, cnt_dec;
  logic [SHIFT_W:0]   head;

  always_comb begin
    empty      = (occ == (AW+1)'(0));
    full       = (occ == DEPTH);
    head       = mem[rd_ptr];
    head_last  = head[SHIFT_W];
    pop        = !empty & l1pa_rdy_i;
`ifdef MEMSHARE_SEQBUF_BYPASS_EN
    bypass     = empty & shift_vld_i & l1pa_rdy_i;
`else
    bypass     = 1'b0;
`endif
    // accept covers both a stored push and a bypassed pattern
    accept     = shift_vld_i & (!full | pop);
    push       = accept & !bypass;
    force_last = !isGtr_i & (seq_len == LEN_LAST);
    last_new   = isGtr_i | force_last;
    cnt_inc    = push & last_new;
    cnt_dec    = pop & head_last;
    stall_o    = (DEPTH - occ) < MAXLEN;
  end

  always_comb begin
    if (bypass) begin
      l1pa_vld_o   = 1'b1;
      l1pa_shift_o = shift_i;
      l1pa_last_o  = last_new;
    end else if (!empty) begin
      l1pa_vld_o   = 1'b1;
      l1pa_shift_o = head[SHIFT_W-1:0];
      l1pa_last_o  = head_last;
    end else begin
      l1pa_vld_o   = 1'b0;
      l1pa_shift_o = {SHIFT_W{1'b0}};
      l1pa_last_o  = 1'b0;
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= {last_new, shift_i};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      occ        <= (AW+1)'(0);
      seq_len    <= {SLW{1'b0}};
      seq_cnt    <= {CNT_W{1'b0}};
      ovf        <= 1'b0;
      seqlen_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      case ({cnt_inc, cnt_dec})
        2'b10:   seq_cnt <= seq_cnt + CNT_W'(1);
        2'b01:   seq_cnt <= seq_cnt - CNT_W'(1);
        default: seq_cnt <= seq_cnt;
      endcase
      if (accept) begin
        seq_len <= last_new ? {SLW{1'b0}} : seq_len + SLW'(1);
      end
      if (accept & force_last) begin
        seqlen_err <= 1'b1;
      end
      // a valid pattern that was not accepted was dropped
      if (shift_vld_i & !accept) begin
        ovf <= 1'b1;
      end
    end
  end

  assign seq_cnt_o    = seq_cnt;
  assign ovf_o        = ovf;
  assign seqlen_err_o = seqlen_err;

endmodule

// File: tb/tb_memshare_shift_seq_buffer.sv
// Table-driven bench for memshare_shift_seq_buffer with hand-written bypass sequence.
module tb_memshare_shift_seq_buffer;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] shift_i = 2'd0;
  logic       isGtr_i = 1'b0;
  logic       shift_vld_i = 1'b0;
  logic       stall_o;
  logic [1:0] l1pa_shift_o;
  logic       l1pa_last_o;
  logic       l1pa_vld_o;
  logic       l1pa_rdy_i = 1'b0;
  logic [3:0] seq_cnt_o;
  logic       ovf_o;
  logic       seqlen_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  memshare_shift_seq_buffer dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .shift_i     (shift_i),
    .isGtr_i     (isGtr_i),
    .shift_vld_i (shift_vld_i),
    .stall_o     (stall_o),
    .l1pa_shift_o(l1pa_shift_o),
    .l1pa_last_o (l1pa_last_o),
    .l1pa_vld_o  (l1pa_vld_o),
    .l1pa_rdy_i  (l1pa_rdy_i),
    .seq_cnt_o   (seq_cnt_o),
    .ovf_o       (ovf_o),
    .seqlen_err_o(seqlen_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit       r, v;
    bit [1:0] s;
    bit       g, rd;
    bit       e_vld;
    bit [1:0] e_sh;
    bit       e_last, e_stall;
    int       e_cnt;
    bit       e_ovf, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit r, bit v, bit [1:0] s, bit g, bit rd,
                     bit ev, bit [1:0] es, bit el, bit est, int ec, bit eo, bit ee);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.g = g; t.rd = rd;
    t.e_vld = ev; t.e_sh = es; t.e_last = el; t.e_stall = est;
    t.e_cnt = ec; t.e_ovf = eo; t.e_err = ee;
    vecs.push_back(t);
  endtask

  task automatic chk(string name, int idx, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic chk_all(int idx, bit ev, bit [1:0] es, bit el, bit est, int ec, bit eo, bit ee);
    chk("l1pa_vld",   idx, int'(l1pa_vld_o),   int'(ev));
    chk("l1pa_shift", idx, int'(l1pa_shift_o), int'(es));
    chk("l1pa_last",  idx, int'(l1pa_last_o),  int'(el));
    chk("stall",      idx, int'(stall_o),      int'(est));
    chk("seq_cnt",    idx, int'(seq_cnt_o),    ec);
    chk("ovf",        idx, int'(ovf_o),        int'(eo));
    chk("seqlen_err", idx, int'(seqlen_err_o), int'(ee));
  endtask

  initial begin
    // reset
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    // 3-pattern sequence, first push with rdy low so it is stored in any build
    add(0,1,1,0,0, 1,1,0,0,0,0,0);
    add(0,1,2,0,1, 1,2,0,0,0,0,0);
    add(0,1,3,1,1, 1,3,1,0,1,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0,0);
    // backpressure: two sequences of 4, head held at (2,0)
    add(0,1,2,0,0, 1,2,0,0,0,0,0);
    add(0,1,1,0,0, 1,2,0,0,0,0,0);
    add(0,1,3,0,0, 1,2,0,0,0,0,0);
    add(0,1,0,1,0, 1,2,0,0,1,0,0);
    add(0,1,1,0,0, 1,2,0,1,1,0,0);
    add(0,1,2,0,0, 1,2,0,1,1,0,0);
    add(0,1,3,0,0, 1,2,0,1,1,0,0);
    add(0,1,3,1,0, 1,2,0,1,2,0,0);
    // full: simultaneous push and pop
    add(0,1,0,0,1, 1,1,0,1,2,0,0);
    // full, no pop: dropped
    add(0,1,1,0,0, 1,1,0,1,2,1,0);
    // drain
    add(0,0,0,0,1, 1,3,0,1,2,1,0);
    add(0,0,0,0,1, 1,0,1,1,2,1,0);
    add(0,0,0,0,1, 1,1,0,1,1,1,0);
    add(0,0,0,0,1, 1,2,0,0,1,1,0);
    add(0,0,0,0,1, 1,3,0,0,1,1,0);
    add(0,0,0,0,1, 1,3,1,0,1,1,0);
    add(0,0,0,0,1, 1,0,0,0,0,1,0);
    add(0,0,0,0,1, 0,0,0,0,0,1,0);
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    // over-long sequence: 4th forced last, 5th starts new sequence
    add(0,1,1,0,0, 1,1,0,0,0,0,0);
    add(0,1,2,0,0, 1,1,0,0,0,0,0);
    add(0,1,3,0,0, 1,1,0,0,0,0,0);
    add(0,1,0,0,0, 1,1,0,0,1,0,1);
    add(0,1,1,0,0, 1,1,0,1,1,0,1);
    add(0,0,0,0,1, 1,2,0,0,1,0,1);
    add(0,0,0,0,1, 1,3,0,0,1,0,1);
    add(0,0,0,0,1, 1,0,1,0,1,0,1);
    add(0,0,0,0,1, 1,1,0,0,0,0,1);
    add(0,0,0,0,1, 0,0,0,0,0,0,1);
    // reset mid-sequence
    add(0,1,1,0,0, 1,1,0,0,0,0,1);
    add(0,1,2,0,0, 1,1,0,0,0,0,1);
    add(1,0,0,0,0, 0,0,0,0,0,0,0);
    add(0,1,3,0,0, 1,3,0,0,0,0,0);
    add(0,1,2,0,0, 1,3,0,0,0,0,0);
    add(0,1,1,0,0, 1,3,0,0,0,0,0);
    add(0,1,0,0,0, 1,3,0,0,1,0,1);
    add(0,0,0,0,1, 1,2,0,0,1,0,1);
    add(0,0,0,0,1, 1,1,0,0,1,0,1);
    add(0,0,0,0,1, 1,0,1,0,1,0,1);
    add(0,0,0,0,1, 0,0,0,0,0,0,1);

    @(negedge sys_clk);
    foreach (vecs[i]) begin
      rst = vecs[i].r; shift_vld_i = vecs[i].v; shift_i = vecs[i].s;
      isGtr_i = vecs[i].g; l1pa_rdy_i = vecs[i].rd;
      @(posedge sys_clk);
      #1;
      rst = 1'b0; shift_vld_i = 1'b0;
      #1;
      chk_all(i, vecs[i].e_vld, vecs[i].e_sh, vecs[i].e_last, vecs[i].e_stall,
              vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_err);
    end

    // bypass sequence on an empty FIFO
    shift_i = 2'd2; isGtr_i = 1'b1; l1pa_rdy_i = 1'b1; shift_vld_i = 1'b1;
    #1;
`ifdef MEMSHARE_SEQBUF_BYPASS_EN
    chk("byp_same_vld",   100, int'(l1pa_vld_o),   1);
    chk("byp_same_shift", 100, int'(l1pa_shift_o), 2);
    chk("byp_same_last",  100, int'(l1pa_last_o),  1);
`else
    chk("byp_same_vld",   100, int'(l1pa_vld_o),   0);
`endif
    @(posedge sys_clk);
    #1;
    shift_vld_i = 1'b0;
    #1;
`ifdef MEMSHARE_SEQBUF_BYPASS_EN
    chk("byp_next_vld", 101, int'(l1pa_vld_o), 0);
    chk("byp_next_cnt", 101, int'(seq_cnt_o),  0);
`else
    chk("byp_next_vld",   101, int'(l1pa_vld_o),   1);
    chk("byp_next_shift", 101, int'(l1pa_shift_o), 2);
    chk("byp_next_last",  101, int'(l1pa_last_o),  1);
    chk("byp_next_cnt",   101, int'(seq_cnt_o),    1);
`endif
    @(posedge sys_clk);
    #1;
    chk("byp_drain_vld", 102, int'(l1pa_vld_o), 0);
    chk("byp_drain_cnt", 102, int'(seq_cnt_o),  0);
    chk("byp_drain_ovf", 102, int'(ovf_o),      0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memshare_shift_seq_buffer.md
Name: memshare_shift_seq_buffer

Overview:
- Downstream stage of the memShare control wrapper. It captures the L1PA shift patterns (l1pa_shift, isGtr) produced by the RFMU every active pipeline cycle.
- Each pattern is tagged with an end-of-sequence flag and held in a small FIFO.
- Patterns are released to the L1PA shifter through a valid/ready handshake, which decouples the regFile read pipeline from L1PA stalls.
- A stall signal goes back to the SCU memShare controller, plus sticky error flags for overflow and over-long sequences.

Parameters:
- SHARE_GROUP_SIZE, 4: requestors per share group; SHIFT_W = $clog2(SHARE_GROUP_SIZE).
- FIFO_DEPTH, 8: number of entries; must be a power of 2 and >= 2*MAX_SEQ_LEN.
- MAX_SEQ_LEN, 4: maximum patterns per L1PA shift sequence (equals L1PA_SEQ_SIZE).

Ports:
- sys_clk, in, 1: system clock. One clock domain only; everything is sampled on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- shift_i, in, SHIFT_W: L1PA shift amount from the RFMU.
- isGtr_i, in, 1: 1 = this pattern is the last of its sequence.
- shift_vld_i, in, 1: pattern valid (scu_memShare_busy qualified).
- stall_o, out, 1: request to upstream to pause issuing new sequences.
- l1pa_shift_o, out, SHIFT_W: head-entry shift amount.
- l1pa_last_o, out, 1: head-entry end-of-sequence flag.
- l1pa_vld_o, out, 1: head entry valid.
- l1pa_rdy_i, in, 1: L1PA accepts the head entry.
- seq_cnt_o, out, $clog2(FIFO_DEPTH)+1: number of complete sequences stored.
- ovf_o, out, 1: sticky; a pattern was dropped.
- seqlen_err_o, out, 1: sticky; a sequence exceeded MAX_SEQ_LEN.

Behaviour:
- Reset (rst=1 at an edge):
  - Read/write pointers, occupancy, sequence-length counter, seq_cnt_o, ovf_o and seqlen_err_o all go to 0.
  - Consequently l1pa_vld_o=0, l1pa_shift_o=0, l1pa_last_o=0 and stall_o=0.
  - A reset arriving mid-sequence discards all stored entries and the partial sequence. The first pattern after reset starts a new sequence.
- Entry format: {last, shift}, width SHIFT_W+1.
- push = shift_vld_i & (!full | pop). A write is accepted when the FIFO is full only if a pop happens in the same cycle.
- pop = l1pa_vld_o & l1pa_rdy_i.
- Shift-out interface:
  - First-word-fall-through FIFO: l1pa_vld_o = !empty, and l1pa_* are driven from the head entry.
  - A pushed entry becomes visible on l1pa_* in the next cycle (latency 1).
  - l1pa_shift_o and l1pa_last_o are held stable while l1pa_vld_o=1 and l1pa_rdy_i=0.
- Sequence length counter (seq_len, 0..MAX_SEQ_LEN-1), advanced on each push:
  - If isGtr_i=1: last=1 and seq_len returns to 0.
  - Else if seq_len==MAX_SEQ_LEN-1: last is forced to 1, seq_len returns to 0, and seqlen_err_o is set.
  - Else: last=0 and seq_len increments.
- Overflow: shift_vld_i=1 with full=1 and no pop drops the pattern and sets ovf_o. seq_len is unchanged.
- seq_cnt_o:
  - +1 on a push with last=1.
  - -1 on a pop whose head has last=1.
  - Unchanged when both happen in the same cycle.
- Occupancy:
  - Pointers wrap modulo FIFO_DEPTH; occupancy is carried with one extra bit.
  - full = (occupancy==FIFO_DEPTH); empty = (occupancy==0).
- stall_o:
  - Combinational: stall_o = (FIFO_DEPTH - occupancy) < MAX_SEQ_LEN.
  - Upstream must not start a new sequence while stall_o=1, but may finish the current one.
- Sticky flags (ovf_o, seqlen_err_o) clear only on rst.

Optional Feature:
- Macro: MEMSHARE_SEQBUF_BYPASS_EN.
- Defined:
  - When empty=1, shift_vld_i=1 and l1pa_rdy_i=1, the pattern is driven combinationally on l1pa_* with l1pa_vld_o=1 in the same cycle.
  - The pattern is not stored and occupancy is unchanged. seq_len and seqlen_err_o update exactly as for a push.
  - seq_cnt_o is unchanged.
- Undefined: no combinational path from shift_i to l1pa_*; the latency is always 1 cycle.

Test Plan:
- Reset, then a 3-pattern sequence:
  - Stimulus: shifts 1, 2, 3 with isGtr 0, 0, 1 and l1pa_rdy_i=1.
  - Required: l1pa_* show (1,0), (2,0), (3,1) one cycle after each push; seq_cnt_o peaks at 1 and returns to 0; no flags set.
- Backpressure and overflow (FIFO_DEPTH=8):
  - Stimulus: l1pa_rdy_i=0; push 8 entries as two sequences of 4 (last on entries 4 and 8), then a 9th pattern.
  - Required: stall_o=1 once occupancy reaches 5; full after 8 pushes; 9th pattern dropped with ovf_o=1; seq_cnt_o=2; head entry held stable throughout.
- Simultaneous push and pop when full:
  - Stimulus: FIFO full, shift_vld_i=1, l1pa_rdy_i=1.
  - Required: entry accepted, occupancy stays 8, ovf_o stays 0.
- Over-long sequence (MAX_SEQ_LEN=4):
  - Stimulus: 5 patterns, all with isGtr_i=0.
  - Required: the 4th entry is stored with last=1 and seqlen_err_o=1; the 5th starts a new sequence with last=0.
- Reset mid-sequence:
  - Stimulus: after 2 non-last pushes with 2 entries buffered, pulse rst for 1 cycle.
  - Required: l1pa_vld_o=0 the next cycle; seq_cnt_o=0; ovf_o and seqlen_err_o cleared; the next 4 non-last patterns store the 4th with last=1.
- Bypass (MEMSHARE_SEQBUF_BYPASS_EN defined):
  - Stimulus: empty FIFO, l1pa_rdy_i=1, shift_i=2, isGtr_i=1.
  - Required: l1pa_vld_o=1 with l1pa_shift_o=2 and l1pa_last_o=1 in the same cycle; occupancy and seq_cnt_o stay 0.
  - With the macro undefined: the same values appear one cycle later.
